// File: rtl/alu_issue_if.sv
// alu_issue_if: bundles the handshake and payload signals of the
// decode-and-issue stage.
//   master : upstream/ALU-side driver (drives instruction, operands, valid,
//            flush and Out_ready_in; observes everything the stage produces)
//   slave  : the alu_issue stage itself
// Parameter CNT_WIDTH sizes Illegal_count_out and must match the stage.
interface alu_issue_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 Flush_in;
  logic [31:0]          Instr_in;
  logic [31:0]          Rs_data_in;
  logic [31:0]          Rt_data_in;
  logic                 In_valid_in;
  logic                 In_ready_out;
  logic [5:0]           Func_out;
  logic [31:0]          A_out;
  logic [31:0]          B_out;
  logic [4:0]           Dest_out;
  logic                 WriteEn_out;
  logic                 MemRead_out;
  logic                 MemWrite_out;
  logic                 Illegal_out;
  logic                 Out_valid_out;
  logic                 Out_ready_in;
  logic [CNT_WIDTH-1:0] Illegal_count_out;

  modport master (
    output Flush_in, Instr_in, Rs_data_in, Rt_data_in, In_valid_in, Out_ready_in,
    input  In_ready_out, Func_out, A_out, B_out, Dest_out, WriteEn_out,
           MemRead_out, MemWrite_out, Illegal_out, Out_valid_out, Illegal_count_out
  );

  modport slave (
    input  Flush_in, Instr_in, Rs_data_in, Rt_data_in, In_valid_in, Out_ready_in,
    output In_ready_out, Func_out, A_out, B_out, Dest_out, WriteEn_out,
           MemRead_out, MemWrite_out, Illegal_out, Out_valid_out, Illegal_count_out
  );
endinterface

// File: rtl/alu_issue.sv
// alu_issue: decodes a MIPS instruction plus rs/rt read data into the ALU
// function code, operands and writeback/memory control, and holds the result
// in a two-entry (main + skid) valid/ready buffer.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - alu_issue_if.slave: Flush_in, Instr_in, Rs/Rt_data_in,
//           In_valid_in/In_ready_out, decoded outputs, Out_valid_out/
//           Out_ready_in, Illegal_count_out
// Configuration macro: ALU_ISSUE_ILLEGAL_CNT_EN enables the saturating
// illegal-instruction counter; without it Illegal_count_out is tied to 0.
module alu_issue #(
  parameter int CNT_WIDTH = 16
) (
  input logic        clk,
  input logic        reset,
  alu_issue_if.slave bus
);

  typedef struct packed {
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  dest;
    logic        we;
    logic        mem_rd;
    logic        mem_wr;
    logic        ill;
  } entry_t;

  localparam entry_t RESET_ENTRY = entry_t'({6'b100001, 73'd0});

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t state_reg, state_next;
  entry_t main_reg, skid_reg;
  entry_t dec;
  logic   in_ready, out_valid, accept, consume;
  logic   load_main_in, load_main_skid, load_skid;

  // ---------------- decode ----------------
  logic [5:0]  op, funct;
  logic [4:0]  rt_f, rd_f, shamt;
  logic [15:0] imm;

  assign op    = bus.Instr_in[31:26];
  assign rt_f  = bus.Instr_in[20:16];
  assign rd_f  = bus.Instr_in[15:11];
  assign shamt = bus.Instr_in[10:6];
  assign funct = bus.Instr_in[5:0];
  assign imm   = bus.Instr_in[15:0];

  always_comb begin
    // Illegal encoding is the default; every recognised form overrides it.
    dec      = '0;
    dec.func = 6'b100001;
    dec.ill  = 1'b1;
    case (op)
      6'h00: begin
        case (funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: begin
            dec = '{func: funct, a: bus.Rs_data_in, b: bus.Rt_data_in, dest: rd_f,
                    we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
          end
          6'h00, 6'h02, 6'h03: begin
            dec = '{func: funct, a: {27'd0, shamt}, b: bus.Rt_data_in, dest: rd_f,
                    we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
          end
          6'h08: begin
            dec = '{func: 6'b111011, a: bus.Rs_data_in, b: 32'd0, dest: 5'd0,
                    we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
          end
          6'h09: begin
            dec = '{func: 6'b111011, a: bus.Rs_data_in, b: 32'd0, dest: rd_f,
                    we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
          end
          default: ;
        endcase
      end
      6'h01: begin
        // REGIMM: only BLTZ (rt=0) and BGEZ (rt=1) are supported.
        if (rt_f == 5'd0 || rt_f == 5'd1) begin
          dec = '{func: {5'b11100, rt_f[0]}, a: bus.Rs_data_in, b: 32'd0, dest: 5'd0,
                  we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
        end
      end
      6'h02, 6'h03: begin
        dec = '{func: 6'b111010, a: {6'd0, bus.Instr_in[25:0]}, b: 32'd0,
                dest: op[0] ? 5'd31 : 5'd0, we: op[0], mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
      end
      6'h04, 6'h05, 6'h06, 6'h07: begin
        dec = '{func: {4'b1111, op[1:0]}, a: bus.Rs_data_in, b: bus.Rt_data_in, dest: 5'd0,
                we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        // ADDI/ADDIU map to add/addu, SLTI/SLTIU to slt/sltu.
        dec = '{func: {2'b10, op[1], 1'b0, op[1], op[0]}, a: bus.Rs_data_in,
                b: {{16{imm[15]}}, imm}, dest: rt_f, we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        dec = '{func: {4'b1001, op[1:0]}, a: bus.Rs_data_in, b: {16'd0, imm}, dest: rt_f,
                we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
      end
      6'h0F: begin
        // LUI is issued as a left shift of the zero-extended immediate by 16.
        dec = '{func: 6'b000000, a: 32'd16, b: {16'd0, imm}, dest: rt_f,
                we: 1'b1, mem_rd: 1'b0, mem_wr: 1'b0, ill: 1'b0};
      end
      6'h23: begin
        dec = '{func: 6'b100001, a: bus.Rs_data_in, b: {{16{imm[15]}}, imm}, dest: rt_f,
                we: 1'b1, mem_rd: 1'b1, mem_wr: 1'b0, ill: 1'b0};
      end
      6'h2B: begin
        dec = '{func: 6'b100001, a: bus.Rs_data_in, b: {{16{imm[15]}}, imm}, dest: 5'd0,
                we: 1'b0, mem_rd: 1'b0, mem_wr: 1'b1, ill: 1'b0};
      end
      default: ;
    endcase
    // $0 is hardwired; never report a write to it.
    if (dec.dest == 5'd0) dec.we = 1'b0;
  end

  // ---------------- occupancy FSM ----------------
  assign in_ready  = (state_reg != ST_TWO);
  assign out_valid = (state_reg != ST_EMPTY);
  assign accept    = bus.In_valid_in & in_ready & ~bus.Flush_in;
  assign consume   = out_valid & bus.Out_ready_in;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_EMPTY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.Flush_in) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: if (accept) state_next = ST_ONE;
        ST_ONE: begin
          if (accept && !consume)      state_next = ST_TWO;
          else if (!accept && consume) state_next = ST_EMPTY;
        end
        ST_TWO:   if (consume) state_next = ST_ONE;
        default:  state_next = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_reg)
      ST_EMPTY: load_main_in = accept;
      ST_ONE: begin
        load_main_in = accept & consume;
        load_skid    = accept & ~consume;
      end
      ST_TWO:   load_main_skid = consume & ~bus.Flush_in;
      default: ;
    endcase
  end

  // ---------------- payload registers ----------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_reg <= RESET_ENTRY;
      skid_reg <= RESET_ENTRY;
    end else begin
      if (load_main_in)        main_reg <= dec;
      else if (load_main_skid) main_reg <= skid_reg;
      if (load_skid)           skid_reg <= dec;
    end
  end

  assign bus.In_ready_out  = in_ready;
  assign bus.Out_valid_out = out_valid;
  assign bus.Func_out      = main_reg.func;
  assign bus.A_out         = main_reg.a;
  assign bus.B_out         = main_reg.b;
  assign bus.Dest_out      = main_reg.dest;
  assign bus.WriteEn_out   = main_reg.we;
  assign bus.MemRead_out   = main_reg.mem_rd;
  assign bus.MemWrite_out  = main_reg.mem_wr;
  assign bus.Illegal_out   = main_reg.ill;

  // ---------------- illegal-instruction counter ----------------
`ifdef ALU_ISSUE_ILLEGAL_CNT_EN
  logic [CNT_WIDTH-1:0] cnt_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= {CNT_WIDTH{1'b0}};
    end else if (accept && dec.ill && cnt_reg != {CNT_WIDTH{1'b1}}) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign bus.Illegal_count_out = cnt_reg;
`else
  assign bus.Illegal_count_out = {CNT_WIDTH{1'b0}};
`endif

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that sits directly upstream of the ALU in the single-cycle MIPS datapath. It converts a raw 32-bit MIPS instruction plus register-file read data into the ALU's 6-bit function code, its A/B operands and writeback/memory control. Results are held in a registered, two-entry (main + skid) valid/ready buffer, so the ALU side can stall without dropping instructions.

## Interface
- `CNT_WIDTH`, default 16: width of the illegal-instruction counter.

- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `Flush_in`  in  1  discard all buffered entries and any same-cycle input
- `Instr_in`  in  32  instruction word
- `Rs_data_in`  in  32  register rs read value
- `Rt_data_in`  in  32  register rt read value
- `In_valid_in`  in  1  upstream offers Instr/Rs/Rt
- `In_ready_out`  out  1  stage can accept; transfer when valid & ready
- `Func_out`  out  6  ALU function code
- `A_out`, `B_out`  out  32  ALU operands
- `Dest_out`  out  5  writeback register
- `WriteEn_out`, `MemRead_out`, `MemWrite_out`  out  1  control bits
- `Illegal_out`  out  1  entry was an unrecognised opcode/funct
- `Out_valid_out`  out  1  head entry valid
- `Out_ready_in`  in  1  ALU side consumes head entry
- `Illegal_count_out`  out  CNT_WIDTH  saturating illegal-instruction count

## Operation
- Decode mapping (op = [31:26], funct = [5:0], imm = [15:0]):
  - R-type arith/logic/slt, funct 0x20–0x27, 0x2A, 0x2B: Func = funct, A = rs, B = rt, Dest = rd, write enabled.
  - SLL / SRL / SRA (funct 0x00 / 0x02 / 0x03): Func = 000000 / 000010 / 000011, A = zext(shamt), B = rt, Dest = rd.
  - JR (0x08): Func = 111011, A = rs, no write.
  - JALR (0x09): Func = 111011, A = rs, Dest = rd, write enabled.
  - ADDI / ADDIU / SLTI / SLTIU (0x08–0x0B): Func = 100000 / 100001 / 101010 / 101011, B = sext(imm), Dest = rt.
  - ANDI / ORI / XORI (0x0C–0x0E): Func = 100100 / 100101 / 100110, B = zext(imm), Dest = rt.
  - LUI (0x0F): Func = 000000, A = 16, B = zext(imm), Dest = rt.
  - LW (0x23): Func = 100001, A = rs, B = sext(imm), Dest = rt, MemRead.
  - SW (0x2B): Func = 100001, A = rs, B = sext(imm), MemWrite, no write.
  - BEQ / BNE / BLEZ / BGTZ (0x04–0x07): Func = 1111xx from op[1:0], A = rs, B = rt, no write.
  - REGIMM (0x01): rt = 0 gives BLTZ (111000); rt = 1 gives BGEZ (111001); any other rt is illegal.
  - J / JAL (0x02 / 0x03): Func = 111010, A = {6'b0, instr[25:0]}. JAL sets Dest = 31, write enabled.
  - Anything else is illegal: Func = 100001, A = B = 0, Dest = 0, all enables 0, Illegal = 1.
- Any write with Dest = 0 forces WriteEn = 0.
- Buffer: main register drives the outputs; a skid register holds one extra entry.
  - `In_ready_out` = ~skid_valid, registered.
  - Accept with main empty, or main consumed in the same cycle: the entry goes to main.
  - Accept while main is held (valid & ~Out_ready_in): the entry goes to skid.
  - When main is consumed and skid is valid, skid moves to main and skid empties.
- States by occupancy: EMPTY → ONE (accept) → TWO (accept while stalled). TWO → ONE (consume). ONE → EMPTY (consume without accept). ONE → ONE (consume + accept).
- Order is strictly FIFO; no entry is ever duplicated or dropped except by flush.

## Timing
- Reset values:
  - Out_valid_out = 0, In_ready_out = 1, Illegal_count_out = 0.
  - Func_out = 100001; A, B, Dest and all enables = 0; Illegal_out = 0.
- Latency: an entry accepted at edge N is presented with Out_valid_out = 1 after edge N, one cycle.
- Throughput: one instruction per cycle while Out_ready_in = 1.
- Out payload is stable while Out_valid_out & ~Out_ready_in.
- Flush_in = 1 at an edge: both valid bits clear and the same-cycle input is discarded even if accepted. In_ready_out = 1 the next cycle. Flush has priority over every other event.
- Reset asserted mid-transfer: takes effect immediately; all outputs go to their reset values asynchronously.

## Configuration
- `ALU_ISSUE_ILLEGAL_CNT_EN` defined: Illegal_count_out increments by 1 each time an illegal entry is accepted (not flushed in the same cycle), saturating at 2^CNT_WIDTH−1.
- Not defined: no counter logic; Illegal_count_out is tied to 0.

## Test plan
- `ADD $3,$1,$2` (0x00221820), Rs = 5, Rt = 7, Out_ready = 1 → next cycle Func = 100000, A = 5, B = 7, Dest = 3, WriteEn = 1.
- `ADDI $2,$0,-1` (0x2002FFFF) and `ORI $2,$0,0xFFFF` → B = 0xFFFFFFFF then 0x0000FFFF. `LUI $4,0x1234` → Func = 000000, A = 16, B = 0x1234.
- Three back-to-back accepts while Out_ready = 0 → In_ready drops after the 2nd accept and the 3rd is not taken. Raise Out_ready → entries drain in order 1, 2, 3 with no gaps.
- `BGEZ` (0x04210004) → Func = 111001, WriteEn = 0. REGIMM with rt = 2 → Illegal = 1, count = 1 with macro defined, 0 without.
- Flush asserted while holding two entries plus a same-cycle accept → Out_valid = 0 the next cycle, In_ready = 1, count unchanged.
- Reset pulsed mid-stream → Out_valid = 0 immediately, Func = 100001, count = 0.
